// File: rtl/wb_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_bus_t
//  Brief    : Wishbone classic bus bundle with initiator and target modports.
//  Revision : 1.0
// ============================================================================
interface wb_bus_t;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_ms;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_sm;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms,
        input  wb_ack, wb_err, wb_dat_sm
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms,
        output wb_ack, wb_err, wb_dat_sm
    );
endinterface
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : wb_initiator
//  Brief    : Single-access Wishbone initiator with valid/ready request and
//             response channels and a bounded wait for ack/err.
//  Revision : 1.0
// ============================================================================
module wb_initiator #(
    parameter int TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        rstn_i,
    input  wire logic        req_valid_i,
    output logic             req_ready_o,
    input  wire logic        req_we_i,
    input  wire logic [31:0] req_adr_i,
    input  wire logic [31:0] req_dat_i,
    output logic             rsp_valid_o,
    input  wire logic        rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_timeout_o,
    output logic             busy_o,
    wb_bus_t.master          wb_bus
);

    localparam int                CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               we_q,      we_d;
    logic [31:0]        adr_q,     adr_d;
    logic [31:0]        dat_q,     dat_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_to_q,  rsp_to_d;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_in_bus;

    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_in_bus  = (state_q == ST_BUS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        rsp_to_d  = rsp_to_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = ST_BUS;
                    we_d    = req_we_i;
                    adr_d   = req_adr_i;
                    dat_d   = req_dat_i;
                    cnt_d   = '0;
                end
            end
            ST_BUS: begin
                if (wb_bus.wb_ack || wb_bus.wb_err) begin
                    // Simultaneous ack+err is reported as an error with no data.
                    state_d   = ST_RESP;
                    rsp_err_d = wb_bus.wb_err;
                    rsp_to_d  = 1'b0;
                    rsp_dat_d = (!we_q && wb_bus.wb_ack && !wb_bus.wb_err)
                                ? wb_bus.wb_dat_sm : 32'd0;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == TIMEOUT_CNT) begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                        rsp_to_d  = 1'b1;
                        rsp_dat_d = 32'd0;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d   = ST_IDLE;
                    rsp_dat_d = 32'd0;
                    rsp_err_d = 1'b0;
                    rsp_to_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            rsp_dat_q <= 32'd0;
            rsp_err_q <= 1'b0;
            rsp_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            rsp_to_q  <= rsp_to_d;
        end
    end

    // Ready is masked by reset so nothing is offered while rstn_i is low.
    assign req_ready_o   = (state_q == ST_IDLE) && rstn_i;
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_to_q;
    assign busy_o        = (state_q != ST_IDLE);

    assign wb_bus.wb_cyc    = w_in_bus;
    assign wb_bus.wb_stb    = w_in_bus;
    assign wb_bus.wb_we     = w_in_bus && we_q;
    assign wb_bus.wb_adr    = w_in_bus ? adr_q : 32'd0;
    assign wb_bus.wb_dat_ms = (w_in_bus && we_q) ? dat_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_initiator
//  Brief    : Directed scoreboard bench for wb_initiator with a simple target.
//  Revision : 1.0
// ============================================================================
module tb_wb_initiator;

    localparam int M_ACK    = 0;
    localparam int M_BOTH   = 1;
    localparam int M_SILENT = 2;
    localparam int M_ERR    = 3;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_adr_i;
    logic [31:0] req_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    int          mode;
    logic [31:0] slave_dat;
    logic        spur_ack;
    logic        spur_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    wb_bus_t bus ();

    assign bus.wb_ack    = spur_ack | (bus.wb_cyc & ((mode == M_ACK) || (mode == M_BOTH)));
    assign bus.wb_err    = spur_err | (bus.wb_cyc & ((mode == M_BOTH) || (mode == M_ERR)));
    assign bus.wb_dat_sm = slave_dat;

    wb_initiator #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rstn_i        (rstn_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_adr_i     (req_adr_i),
        .req_dat_i     (req_dat_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_dat_o     (rsp_dat_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o),
        .wb_bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pops one expected response per completed response handshake.
    always @(negedge clk) begin
        if (rstn_i === 1'b1 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got dat=0x%08h err=%0b to=%0b expected none",
                         rsp_dat_o, rsp_err_o, rsp_timeout_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_dat", rsp_dat_o, e.dat);
                chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
                chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.to));
            end
        end
    end

    // One full access with rsp_ready_i high; ecyc is the expected wb_cyc-high count.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input int smode, input logic [31:0] sdat,
                       input logic [31:0] edat, input logic eerr, input logic eto,
                       input int ecyc);
        int          lat;
        int          cyc_n;
        logic        we_seen;
        logic [31:0] adr_seen;
        logic [31:0] dms_seen;
        exp_t        e;
        e.dat = edat; e.err = eerr; e.to = eto;
        sb.push_back(e);
        mode      = smode;
        slave_dat = sdat;
        lat = 0; cyc_n = 0; we_seen = 1'b0; adr_seen = 32'd0; dms_seen = 32'd0;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.wb_cyc === 1'b1) begin
                if (cyc_n == 0) begin
                    we_seen  = bus.wb_we;
                    adr_seen = bus.wb_adr;
                    dms_seen = bus.wb_dat_ms;
                end
                cyc_n++;
            end
        end while (rsp_valid_o !== 1'b1 && lat < 200);
        if (lat >= 200) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait: got no rsp_valid_o within 200 cycles expected %0d", ecyc + 1);
        end
        chk("rsp_latency", 32'(lat), 32'(ecyc + 1));
        chk("cyc_cycles", 32'(cyc_n), 32'(ecyc));
        chk("wb_we", 32'(we_seen), 32'(we));
        chk("wb_adr", adr_seen, adr);
        chk("wb_dat_ms", dms_seen, we ? dat : 32'd0);
        chk("busy_resp", 32'(busy_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("gap_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("busy_idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   bad;
        rstn_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
        req_adr_i = 32'd0; req_dat_i = 32'd0; rsp_ready_i = 1'b1;
        mode = M_ACK; slave_dat = 32'd0; spur_ack = 1'b0; spur_err = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("rst_stb", 32'(bus.wb_stb), 32'd0);
        chk("rst_we", 32'(bus.wb_we), 32'd0);
        chk("rst_adr", bus.wb_adr, 32'd0);
        chk("rst_dat_ms", bus.wb_dat_ms, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_dat", rsp_dat_o, 32'd0);
        chk("rst_rsp_err", 32'({rsp_err_o, rsp_timeout_o}), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(negedge clk);
        chk("release_req_ready", 32'(req_ready_o), 32'd1);

        txn(1'b1, 32'h0000_0000, 32'h0000_00FF, M_ACK,    32'h1234_5678, 32'd0,         1'b0, 1'b0, 1);
        txn(1'b0, 32'h0000_0004, 32'd0,         M_ACK,    32'h0000_00A5, 32'h0000_00A5, 1'b0, 1'b0, 1);
        txn(1'b0, 32'h0000_0014, 32'd0,         M_BOTH,   32'h0000_00A5, 32'd0,         1'b1, 1'b0, 1);
        txn(1'b0, 32'h0000_0018, 32'd0,         M_ERR,    32'h0000_0077, 32'd0,         1'b1, 1'b0, 1);
        txn(1'b0, 32'h0000_000C, 32'd0,         M_SILENT, 32'h0000_0099, 32'd0,         1'b1, 1'b1, 16);

        // Response backpressure with a second request already waiting.
        mode = M_ACK; slave_dat = 32'h3C3C_3C3C; rsp_ready_i = 1'b0;
        e.dat = 32'h3C3C_3C3C; e.err = 1'b0; e.to = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h0000_0008;
        @(posedge clk); #1;
        req_we_i = 1'b1; req_adr_i = 32'h0000_0010; req_dat_i = 32'h0000_0055;
        @(negedge clk);
        chk("bp_cyc_bus", 32'(bus.wb_cyc), 32'd1);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_rsp_dat", rsp_dat_o, 32'h3C3C_3C3C);
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
            chk("bp_cyc", 32'(bus.wb_cyc), 32'd0);
            @(posedge clk);
        end
        #1;
        rsp_ready_i = 1'b1;
        e.dat = 32'd0; e.err = 1'b0; e.to = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk("bp_after_ready", 32'(req_ready_o), 32'd1);
        chk("bp_after_cyc", 32'(bus.wb_cyc), 32'd0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("bp_next_cyc", 32'(bus.wb_cyc), 32'd1);
        chk("bp_next_dat_ms", bus.wb_dat_ms, 32'h0000_0055);
        chk("bp_next_adr", bus.wb_adr, 32'h0000_0010);
        @(negedge clk);
        chk("bp_next_rsp_valid", 32'(rsp_valid_o), 32'd1);
        @(posedge clk);

        // Stray ack/err while idle must be ignored.
        @(posedge clk); #1;
        spur_ack = 1'b1; spur_err = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        chk("idle_spurious", 32'(bad), 32'd0);
        @(posedge clk); #1;
        spur_ack = 1'b0; spur_err = 1'b0;

        // Reset pulse while the access is waiting on the bus.
        mode = M_SILENT;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h0000_0020;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("rb_cyc_before", 32'(bus.wb_cyc), 32'd1);
        @(posedge clk); #1;
        rstn_i = 1'b0;
        @(negedge clk);
        chk("rb_req_ready_low", 32'(req_ready_o), 32'd0);
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(negedge clk);
        chk("rb_cyc_after", 32'(bus.wb_cyc), 32'd0);
        chk("rb_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rb_req_ready", 32'(req_ready_o), 32'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || bus.wb_cyc !== 1'b0) bad++;
        end
        chk("rb_no_rsp", 32'(bad), 32'd0);

        txn(1'b0, 32'h0000_0004, 32'd0, M_ACK, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: maximum bus cycles waited for wb_ack/wb_err before abort; legal range 1..65535.
REQ-002 Ports SHALL be: clk  in  1  sole clock, all logic on rising edge.
REQ-003 rstn_i  in  1  reset, synchronous and active-low.
REQ-004 req_valid_i  in  1  request command valid.
REQ-005 req_ready_o  out  1  block accepts request this cycle.
REQ-006 req_we_i  in  1  1 = write, 0 = read.
REQ-007 req_adr_i  in  32  byte address of the access.
REQ-008 req_dat_i  in  32  write data.
REQ-009 rsp_valid_o  out  1  response valid.
REQ-010 rsp_ready_i  in  1  response consumer ready.
REQ-011 rsp_dat_o  out  32  read data; 0 for writes, errors and timeouts.
REQ-012 rsp_err_o  out  1  access ended in wb_err or timeout.
REQ-013 rsp_timeout_o  out  1  access ended by timeout.
REQ-014 busy_o  out  1  FSM not in IDLE.
REQ-015 wb_bus  wb_bus_t.master  -  Wishbone initiator port: drives wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms; samples wb_ack, wb_err, wb_dat_sm.

Function
REQ-016 The FSM SHALL have states IDLE, BUS and RESP, all outputs registered or decoded from state and registers only.
REQ-017 IDLE: req_ready_o=1; on req_valid_i=1, latch we/adr/dat and enter BUS at the next edge.
REQ-018 BUS: wb_cyc=wb_stb=1, wb_adr/wb_we held at latched values, wb_dat_ms = latched data if write, else 0; req_ready_o=0.
REQ-019 Outside BUS, wb_cyc, wb_stb and wb_we SHALL be 0, and wb_adr/wb_dat_ms SHALL be 0.
REQ-020 In BUS, wb_ack or wb_err sampled high SHALL end the access: next state RESP, wb_cyc/wb_stb low from the next cycle.
REQ-021 On termination, rsp_err_o SHALL be wb_err, rsp_timeout_o=0, and rsp_dat_o SHALL be wb_dat_sm only for a read with wb_ack=1 and wb_err=0, else 0.
REQ-022 wb_ack and wb_err high together SHALL be treated as error: rsp_err_o=1, rsp_dat_o=0.
REQ-023 A wait counter SHALL clear on entering BUS and increment each BUS cycle without termination.
REQ-024 A counter value of TIMEOUT with no termination SHALL abort the access: next state RESP, rsp_err_o=1, rsp_timeout_o=1, rsp_dat_o=0, cyc/stb low. wb_cyc is therefore high for exactly TIMEOUT cycles.
REQ-025 The counter width SHALL hold TIMEOUT without wrap.
REQ-026 RESP: rsp_valid_o=1, with rsp_dat_o/rsp_err_o/rsp_timeout_o stable until rsp_ready_i=1; then IDLE at the next edge.
REQ-027 Against a slave acking combinationally in its first cycle, latency SHALL be: request accepted at cycle N, wb_cyc high at N+1 only, rsp_valid_o at N+2; minimum three cycles per transaction.
REQ-028 At least one cycle with wb_cyc=0 SHALL separate consecutive accesses.
REQ-029 wb_ack/wb_err in IDLE or RESP SHALL be ignored, with no state or response change.
REQ-030 busy_o SHALL be 1 in BUS and RESP, 0 in IDLE.

Reset
REQ-031 With rstn_i=0 at a clock edge, the next state SHALL be IDLE with counter 0, wb_cyc=wb_stb=wb_we=0, wb_adr=wb_dat_ms=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, rsp_timeout_o=0 and busy_o=0.
REQ-032 req_ready_o SHALL be 0 while rstn_i=0 and 1 in the first cycle after release.
REQ-033 Reset during BUS or RESP SHALL abandon the transaction without producing a response.
REQ-034 Reset SHALL be sampled only on clk; no asynchronous path.

Verification
REQ-035 Write 0x000000FF to adr 0x00 on a combinational-ack slave -> wb_cyc high one cycle with wb_we=1 and wb_dat_ms=0xFF; rsp_valid_o two cycles after accept; rsp_err_o=0; rsp_dat_o=0.
REQ-036 Read adr 0x04, slave returns 0x000000A5 -> rsp_dat_o=0x000000A5, rsp_err_o=0, wb_we=0.
REQ-037 Read adr 0x14, slave asserts wb_ack and wb_err -> rsp_err_o=1, rsp_timeout_o=0, rsp_dat_o=0.
REQ-038 Silent slave, TIMEOUT=16 -> wb_cyc high exactly 16 cycles; rsp_err_o=1, rsp_timeout_o=1.
REQ-039 rsp_ready_i low 5 cycles with req_valid_i high -> response stable, req_ready_o=0, wb_cyc=0; next request accepted in the cycle after handshake plus one.
REQ-040 rstn_i low one cycle during BUS -> next cycle wb_cyc=0, rsp_valid_o=0; after release req_ready_o=1 and no response emitted.
